// File: rtl/vreg_write_arbiter.sv
// ---------------------------------------------------------------------------
// vreg_write_arbiter
//
// Shares the single write port of the vector register file between N_REQ
// requesters. A round-robin arbiter picks one requester in IDLE, then a
// BURST sequence writes one lane element per clock into the granted
// destination register until the latched length is reached.
//
// Optional build macro: VREG_WARB_PRIO_EN
//   defined   -> requester 0 has fixed top priority; the round-robin pointer
//                is left unchanged by a requester-0 grant.
//   undefined -> pure round-robin over all requesters.
//
// Ports:
//   CLK       rising-edge clock
//   RST       asynchronous, active-low reset
//   REQ       per-requester write request, held until DONE
//   REQ_ADDR  destination register per requester (slice i)
//   REQ_LEN   burst length minus one per requester (slice i)
//   REQ_DATA  current lane element per requester (slice i)
//   GNT       one-hot grant, high for the whole burst
//   BEAT_ACK  element consumed this cycle (requester advances REQ_DATA)
//   DONE      one-cycle pulse on the last beat
//   WE        register file write enable
//   WADDR     register file destination register
//   WLANE     lane being written
//   WDATA     write data
//   BUSY      burst in progress
// ---------------------------------------------------------------------------
module vreg_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 32,
  parameter int ADDR_W    = 3,
  parameter int LANE_W    = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           REQ,
  input  logic [N_REQ*ADDR_W-1:0]    REQ_ADDR,
  input  logic [N_REQ*LANE_W-1:0]    REQ_LEN,
  input  logic [N_REQ*DATA_SIZE-1:0] REQ_DATA,
  output logic [N_REQ-1:0]           GNT,
  output logic [N_REQ-1:0]           BEAT_ACK,
  output logic [N_REQ-1:0]           DONE,
  output logic                       WE,
  output logic [ADDR_W-1:0]          WADDR,
  output logic [LANE_W-1:0]          WLANE,
  output logic [DATA_SIZE-1:0]       WDATA,
  output logic                       BUSY
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LANE_W-1:0]    len_q, len_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 busy_q, busy_d;

  // Per-requester views of the packed input buses.
  logic [ADDR_W-1:0]    addr_arr [N_REQ];
  logic [LANE_W-1:0]    len_arr  [N_REQ];
  logic [DATA_SIZE-1:0] data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = REQ_ADDR[gi*ADDR_W +: ADDR_W];
    assign len_arr[gi]  = REQ_LEN[gi*LANE_W +: LANE_W];
    assign data_arr[gi] = REQ_DATA[gi*DATA_SIZE +: DATA_SIZE];
  end

  // Round-robin search starting one past the pointer, wrapping modulo N_REQ.
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand_idx = IDX_W'((int'(ptr_q) + off) % N_REQ);
      if (!rr_found && REQ[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Requester 0 override; when it wins the pointer is not advanced so the
  // rotation among the remaining requesters is unaffected.
  logic             prio0;
  logic [IDX_W-1:0] win_idx;

`ifdef VREG_WARB_PRIO_EN
  assign prio0 = REQ[0];
`else
  assign prio0 = 1'b0;
`endif

  assign win_idx = prio0 ? '0 : rr_idx;

  // Burst datapath. WE drops combinationally if the granted requester
  // withdraws, so nothing is written for the abandoned lane.
  logic in_burst;
  logic last_beat;

  assign in_burst  = (state_q == BURST);
  assign last_beat = (lane_q == len_q);
  assign WE        = in_burst && REQ[gidx_q];
  assign WADDR     = in_burst ? addr_q : '0;
  assign WLANE     = lane_q;
  assign WDATA     = in_burst ? data_arr[gidx_q] : '0;
  assign GNT       = gnt_q;
  assign BUSY      = busy_q;
  assign BEAT_ACK  = WE ? gnt_q : '0;
  assign DONE      = (WE && last_beat) ? gnt_q : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    lane_d  = lane_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          gidx_d          = win_idx;
          ptr_d           = prio0 ? ptr_q : win_idx;
          addr_d          = addr_arr[win_idx];
          len_d           = len_arr[win_idx];
          lane_d          = '0;
          gnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          busy_d          = 1'b1;
          state_d         = BURST;
        end
      end
      BURST: begin
        // Either a completed burst or a withdrawn request ends the burst;
        // the lane counter wraps naturally when LEN is the maximum.
        if (!REQ[gidx_q] || last_beat) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          lane_d  = '0;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      gidx_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      lane_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vreg_write_arbiter
//
// Scoreboard bench: stimulus pushes the expected write beats into a queue,
// a monitor pops and compares on every cycle the DUT asserts WE.
// Requesters are modelled as counters: REQ_DATA slice i = base[i] + beat[i],
// beat[i] advancing after each edge with BEAT_ACK[i] high.
// ---------------------------------------------------------------------------
module tb_vreg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int LW = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr_p;
  logic [N*LW-1:0] req_len_p;
  logic [N*DW-1:0] req_data_p;
  logic [N-1:0]  GNT, BEAT_ACK, DONE;
  logic          WE, BUSY;
  logic [AW-1:0] WADDR;
  logic [LW-1:0] WLANE;
  logic [DW-1:0] WDATA;

  logic [AW-1:0] addr [N];
  logic [LW-1:0] len  [N];
  logic [DW-1:0] base [N];
  int            beat [N];
  logic [N-1:0]  hold;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_addr_p[gi*AW +: AW] = addr[gi];
    assign req_len_p[gi*LW +: LW]  = len[gi];
    assign req_data_p[gi*DW +: DW] = base[gi] + DW'(beat[gi]);
  end

  vreg_write_arbiter #(.N_REQ(N), .DATA_SIZE(DW), .ADDR_W(AW), .LANE_W(LW)) dut (
    .CLK(CLK), .RST(RST), .REQ(req), .REQ_ADDR(req_addr_p), .REQ_LEN(req_len_p),
    .REQ_DATA(req_data_p), .GNT(GNT), .BEAT_ACK(BEAT_ACK), .DONE(DONE), .WE(WE),
    .WADDR(WADDR), .WLANE(WLANE), .WDATA(WDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            g;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [DW-1:0] d;
    bit            done;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_burst(input int g, input logic [AW-1:0] a, input int ln,
                            input logic [DW-1:0] d0, input bit done_last);
    for (int k = 0; k <= ln; k++) begin
      exp_t e;
      e.g = g; e.a = a; e.l = LW'(k); e.d = d0 + DW'(k);
      e.done = done_last && (k == ln);
      q.push_back(e);
    end
  endtask

  // One clock of the requester model; called and returns at posedge+1.
  task automatic tick();
    logic [N-1:0] ack_s, done_s;
    @(negedge CLK);
    ack_s  = BEAT_ACK;
    done_s = DONE;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_s[i]) beat[i]++;
      if (done_s[i] && !hold[i]) req[i] = 1'b0;
    end
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (!(q.size() == 0 && !BUSY)) begin
      if (c >= maxc) begin
        n_checks++;
        $display("FAIL drain_timeout: got %0d beats pending busy=%0b required 0 pending idle", q.size(), BUSY);
        break;
      end
      tick();
      c++;
    end
  endtask

  task automatic reset_dut();
    RST = 1'b0;
    #1;
    chk_eq("reset_outputs", {GNT, DONE, WE, BUSY, WADDR, WLANE, BEAT_ACK}, '0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares every write beat against the scoreboard.
  initial begin : monitor
    bit prev_done = 1'b0;
    exp_t e;
    logic [N-1:0] eg;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_done = 1'b0;
      end else begin
        chk_eq("gnt_onehot0", 64'($onehot0(GNT)), 64'd1);
        if (prev_done) chk_eq("gap_after_done", {WE, BUSY}, 2'b00);
        prev_done = |DONE;
        if (WE) begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_we: got WE=1 gnt=%b lane=%0d required no write", GNT, WLANE);
          end else begin
            e  = q.pop_front();
            eg = N'(1) << e.g;
            $display("beat gnt=%b addr=%0d lane=%0d data=%0h done=%b", GNT, WADDR, WLANE, WDATA, DONE);
            chk_eq("beat", {GNT, WADDR, WLANE, WDATA, DONE, BEAT_ACK},
                   {eg, e.a, e.l, e.d, (e.done ? eg : 4'b0000), eg});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    req = '0; hold = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0; len[i] = '0; base[i] = '0; beat[i] = 0;
    end
    repeat (2) @(posedge CLK);
    #1;
    reset_dut();

    // Single 4-beat burst from requester 0, with IDLE latency check.
    addr[0] = 3'd5; len[0] = 3'd3; base[0] = 32'hA0; beat[0] = 0;
    req = 4'b0001;
    push_burst(0, 3'd5, 3, 32'hA0, 1'b1);
    @(negedge CLK);
    chk_eq("latency_no_we_before_grant", {WE, BUSY}, 2'b00);
    @(posedge CLK);
    #1;
    drain(40);
    @(negedge CLK);
    chk_eq("idle_after_burst", {BUSY, WE, GNT, WADDR, WLANE}, '0);
    @(posedge CLK);
    #1;

    // Two simultaneous single-beat requests: 1 then 2.
    addr[1] = 3'd1; addr[2] = 3'd2; len[1] = 3'd0; len[2] = 3'd0;
    base[1] = 32'hB0; base[2] = 32'hC0; beat[1] = 0; beat[2] = 0;
    push_burst(1, 3'd1, 0, 32'hB0, 1'b1);
    push_burst(2, 3'd2, 0, 32'hC0, 1'b1);
    req = 4'b0110;
    drain(40);

    // All four held continuously, LEN=1: order 0,1,2,3,0.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(4 + i); len[i] = 3'd1; base[i] = DW'(32'h10 * (i + 1)); beat[i] = 0;
    end
    push_burst(0, 3'd4, 1, 32'h10, 1'b1);
    push_burst(1, 3'd5, 1, 32'h20, 1'b1);
    push_burst(2, 3'd6, 1, 32'h30, 1'b1);
    push_burst(3, 3'd7, 1, 32'h40, 1'b1);
    push_burst(0, 3'd4, 1, 32'h12, 1'b1);
    hold = 4'b1111;
    req  = 4'b1111;
    drain(80);
    req = '0; hold = '0;

    // LEN=7, requester 2 withdraws during lane 4, then re-requests.
    addr[2] = 3'd3; len[2] = 3'd7; base[2] = 32'h50; beat[2] = 0;
    push_burst(2, 3'd3, 3, 32'h50, 1'b0);
    tick();
    req = 4'b0100;
    repeat (5) tick();
    req[2] = 1'b0;
    @(negedge CLK);
    chk_eq("drop_we_low", {WE, DONE, BEAT_ACK, BUSY, WLANE}, {1'b0, 4'b0, 4'b0, 1'b1, 3'd4});
    @(posedge CLK);
    #1;
    chk_eq("drop_back_idle", {BUSY, GNT, WLANE, 32'(q.size())}, '0);
    beat[2] = 0;
    req[2]  = 1'b1;
    push_burst(2, 3'd3, 7, 32'h50, 1'b1);
    drain(40);

    // Reset during lane 2, then 0 and 3 request together.
    addr[1] = 3'd1; len[1] = 3'd7; base[1] = 32'hB0; beat[1] = 0;
    push_burst(1, 3'd1, 1, 32'hB0, 1'b0);
    req = 4'b0010;
    repeat (3) tick();
    RST = 1'b0;
    #1;
    chk_eq("async_reset_midburst", {WE, GNT, BUSY, DONE, WLANE, 32'(q.size())}, '0);
    req = '0;
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    addr[0] = 3'd2; addr[3] = 3'd6; len[0] = 3'd0; len[3] = 3'd0;
    base[0] = 32'hD0; base[3] = 32'hE0; beat[0] = 0; beat[3] = 0;
    push_burst(0, 3'd2, 0, 32'hD0, 1'b1);
    push_burst(3, 3'd6, 0, 32'hE0, 1'b1);
    req = 4'b1001;
    drain(40);

    // Pointer at 1 after a grant to 1; then 0 and 2 together.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(i); len[i] = 3'd0; base[i] = DW'(32'h100 * (i + 1)); beat[i] = 0;
    end
    push_burst(1, 3'd1, 0, 32'h200, 1'b1);
    req = 4'b0010;
    drain(40);
`ifdef VREG_WARB_PRIO_EN
    push_burst(0, 3'd0, 0, 32'h100, 1'b1);
    push_burst(2, 3'd2, 0, 32'h300, 1'b1);
`else
    push_burst(2, 3'd2, 0, 32'h300, 1'b1);
    push_burst(0, 3'd0, 0, 32'h100, 1'b1);
`endif
    req = 4'b0101;
    drain(40);

    // REQ=1011 from reset: 0, then 1, then 3 in either build.
    reset_dut();
    for (int i = 0; i < N; i++) beat[i] = 0;
    push_burst(0, 3'd0, 0, 32'h100, 1'b1);
    push_burst(1, 3'd1, 0, 32'h200, 1'b1);
    push_burst(3, 3'd3, 0, 32'h400, 1'b1);
    req = 4'b1011;
    drain(40);

    repeat (2) tick();
    chk_eq("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
